// File: rtl/edge_gen_pkg.sv
// Shared constants, FSM state type and sizing helper for the edge level rebuilder.
package edge_gen_pkg;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_CONFLICT  = 2'd1;
  localparam logic [1:0] ERR_REDUNDANT = 2'd2;
  localparam logic [1:0] ERR_CANCEL    = 2'd3;

  // Bit 1 is the level, bit 0 marks a running hold timer.
  typedef enum logic [1:0] {
    LOW_IDLE  = 2'b00,
    LOW_HOLD  = 2'b01,
    HIGH_IDLE = 2'b10,
    HIGH_HOLD = 2'b11
  } state_e;

  // Hold counter must represent max(MIN_HIGH, MIN_LOW) - 1; one spare keeps width >= 1.
  function automatic int unsigned hold_cnt_w(input int unsigned min_high,
                                             input int unsigned min_low);
    int unsigned m;
    m = (min_high > min_low) ? min_high : min_low;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/edge_hold_timer.sv
// Loadable down-counter enforcing the minimum hold time after each level change.
module edge_hold_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         busy,
  output logic         expire,
  output logic         last
);

  logic [W-1:0] cnt_q;

  // Load on a level change, otherwise count down to zero and stay there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Status decode; last flags the final hold cycle so the FSM can drop to idle with the counter.
  always_comb begin
    busy   = (cnt_q != '0);
    expire = (cnt_q == '0);
    last   = (cnt_q == W'(1));
  end

endmodule

// File: rtl/edge_level_rebuilder.sv
// Rebuilds a level line from rise/fall event pulses, honouring minimum high/low hold times.
// One early request can be parked while the hold timer runs; rejected requests raise err.
module edge_level_rebuilder
  import edge_gen_pkg::*;
#(
  parameter int unsigned MIN_HIGH = 4,
  parameter int unsigned MIN_LOW  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             off,
  output logic             signal,
  output logic             busy,
  output logic             pending,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] edges
);

  localparam int unsigned CW = hold_cnt_w(MIN_HIGH, MIN_LOW);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(MIN_LOW - 1);

  state_e           state_q;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] edges_q;

  logic             level;
  logic             apply;
  logic             expire, last, timer_busy;
  logic             conflict, toward_level, against_level;
  logic [CW-1:0]    load_val;

  assign level = (state_q == HIGH_IDLE) || (state_q == HIGH_HOLD);

  // Request decode: toward_level repeats the current level, against_level asks for a change.
  always_comb begin
    conflict      = on & off;
    toward_level  = level ? (on & ~off) : (off & ~on);
    against_level = level ? (off & ~on) : (on & ~off);
    load_val      = level ? LOW_LOAD : HIGH_LOAD;
  end

  // Decide whether a transition happens this cycle and what the pending slot and err become.
  // A parked request is always opposite to the level, so a toward_level request cancels it.
  always_comb begin
    apply     = 1'b0;
    pending_d = pending_q;
    err_d     = 1'b0;
    code_d    = ERR_NONE;
    if (conflict) begin
      err_d  = 1'b1;
      code_d = ERR_CONFLICT;
      if (pending_q && expire) begin
        apply     = 1'b1;
        pending_d = 1'b0;
      end
    end else if (pending_q) begin
      if (toward_level) begin
        pending_d = 1'b0;
        err_d     = 1'b1;
        code_d    = ERR_CANCEL;
      end else begin
        if (against_level) begin
          err_d  = 1'b1;
          code_d = ERR_REDUNDANT;
        end
        if (expire) begin
          apply     = 1'b1;
          pending_d = 1'b0;
        end
      end
    end else if (toward_level) begin
      err_d  = 1'b1;
      code_d = ERR_REDUNDANT;
    end else if (against_level) begin
      if (expire) begin
        apply = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  edge_hold_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (apply),
    .load_val (load_val),
    .busy     (timer_busy),
    .expire   (expire),
    .last     (last)
  );

  // FSM, pending slot, error flags and transition counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOW_IDLE;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      edges_q   <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      code_q    <= code_d;
      if (apply) begin
        edges_q <= edges_q + CNT_W'(1);
        if (level) begin
          state_q <= (LOW_LOAD != '0) ? LOW_HOLD : LOW_IDLE;
        end else begin
          state_q <= (HIGH_LOAD != '0) ? HIGH_HOLD : HIGH_IDLE;
        end
      end else if (last) begin
        state_q <= level ? HIGH_IDLE : LOW_IDLE;
      end
    end
  end

  assign signal   = level;
  assign busy     = timer_busy;
  assign pending  = pending_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign edges    = edges_q;

endmodule

// File: tb/tb_edge_level_rebuilder.sv
// Directed bench for edge_level_rebuilder: hold timing, parking, error codes, wrap and reset.
module tb_edge_level_rebuilder;

  logic       clk = 1'b0;
  logic       rst;
  logic       on_a, off_a, on_b, off_b;
  logic       sig_a, busy_a, pend_a, err_a;
  logic       sig_b, busy_b, pend_b, err_b;
  logic [1:0] code_a, code_b;
  logic [7:0] edges_a;
  logic [1:0] edges_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  edge_level_rebuilder #(
    .MIN_HIGH (4),
    .MIN_LOW  (4),
    .CNT_W    (8)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .on       (on_a),
    .off      (off_a),
    .signal   (sig_a),
    .busy     (busy_a),
    .pending  (pend_a),
    .err      (err_a),
    .err_code (code_a),
    .edges    (edges_a)
  );

  edge_level_rebuilder #(
    .MIN_HIGH (1),
    .MIN_LOW  (1),
    .CNT_W    (2)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .on       (on_b),
    .off      (off_b),
    .signal   (sig_b),
    .busy     (busy_b),
    .pending  (pend_b),
    .err      (err_b),
    .err_code (code_b),
    .edges    (edges_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; on_a = 0; off_a = 0; on_b = 0; off_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_signal", sig_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pending", pend_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_edges", edges_a, 0);
    rst = 1'b0;
    tick();

    // 1: rise, early fall parked and applied after MIN_HIGH cycles.
    on_a = 1; tick(); on_a = 0;
    chk("t1_rise_sig", sig_a, 1);
    chk("t1_rise_busy", busy_a, 1);
    chk("t1_rise_edges", edges_a, 1);
    tick();
    off_a = 1; tick(); off_a = 0;
    chk("t1_park_pend", pend_a, 1);
    chk("t1_park_sig", sig_a, 1);
    chk("t1_park_err", err_a, 0);
    tick();
    chk("t1_last_high_sig", sig_a, 1);
    chk("t1_last_high_busy", busy_a, 0);
    chk("t1_last_high_pend", pend_a, 1);
    tick();
    chk("t1_fall_sig", sig_a, 0);
    chk("t1_fall_pend", pend_a, 0);
    chk("t1_fall_edges", edges_a, 2);
    chk("t1_fall_busy", busy_a, 1);
    repeat (3) tick();
    chk("t1_low_idle", busy_a, 0);

    // 2: idle rise, busy for MIN_HIGH-1 cycles, then idle fall.
    on_a = 1; tick(); on_a = 0;
    chk("t2_rise_sig", sig_a, 1);
    chk("t2_rise_edges", edges_a, 3);
    tick();
    chk("t2_busy_2", busy_a, 1);
    tick();
    chk("t2_busy_3", busy_a, 1);
    tick();
    chk("t2_busy_4", busy_a, 0);
    chk("t2_hold_sig", sig_a, 1);
    repeat (2) tick();
    off_a = 1; tick(); off_a = 0;
    chk("t2_fall_sig", sig_a, 0);
    chk("t2_fall_edges", edges_a, 4);
    repeat (3) tick();

    // 3: simultaneous on/off is a conflict.
    on_a = 1; off_a = 1; tick(); on_a = 0; off_a = 0;
    chk("t3_err", err_a, 1);
    chk("t3_code", code_a, 1);
    chk("t3_sig", sig_a, 0);
    chk("t3_edges", edges_a, 4);
    tick();
    chk("t3_err_clear", err_a, 0);
    chk("t3_code_clear", code_a, 0);

    // 4: parked fall cancelled by a rise request during the high hold.
    on_a = 1; tick(); on_a = 0;
    chk("t4_rise_edges", edges_a, 5);
    off_a = 1; tick(); off_a = 0;
    chk("t4_park_pend", pend_a, 1);
    on_a = 1; tick(); on_a = 0;
    chk("t4_cancel_err", err_a, 1);
    chk("t4_cancel_code", code_a, 3);
    chk("t4_cancel_pend", pend_a, 0);
    chk("t4_cancel_sig", sig_a, 1);
    tick();
    tick();
    chk("t4_after_sig", sig_a, 1);
    chk("t4_after_edges", edges_a, 5);

    // 5: redundant requests in idle.
    on_a = 1; tick(); on_a = 0;
    chk("t5_on_redund_err", err_a, 1);
    chk("t5_on_redund_code", code_a, 2);
    chk("t5_on_redund_sig", sig_a, 1);
    off_a = 1; tick(); off_a = 0;
    chk("t5_fall_sig", sig_a, 0);
    chk("t5_fall_edges", edges_a, 6);
    repeat (3) tick();
    off_a = 1; tick(); off_a = 0;
    chk("t5_off1_code", code_a, 2);
    tick();
    chk("t5_gap_err", err_a, 0);
    off_a = 1; tick(); off_a = 0;
    chk("t5_off2_code", code_a, 2);
    chk("t5_off2_sig", sig_a, 0);
    chk("t5_off2_edges", edges_a, 6);

    // 6: MIN=1 toggles every cycle; 2-bit edge counter wraps 3 -> 0.
    on_b = 1; tick(); on_b = 0;
    chk("t6_sig_1", sig_b, 1);
    chk("t6_edges_1", edges_b, 1);
    chk("t6_busy_1", busy_b, 0);
    off_b = 1; tick(); off_b = 0;
    chk("t6_sig_2", sig_b, 0);
    chk("t6_edges_2", edges_b, 2);
    on_b = 1; tick(); on_b = 0;
    chk("t6_sig_3", sig_b, 1);
    chk("t6_edges_3", edges_b, 3);
    off_b = 1; tick(); off_b = 0;
    chk("t6_sig_4", sig_b, 0);
    chk("t6_edges_wrap", edges_b, 0);
    chk("t6_err", err_b, 0);

    // 7: asynchronous reset mid-hold with a parked request.
    on_a = 1; tick(); on_a = 0;
    chk("t7_rise_sig", sig_a, 1);
    off_a = 1; tick(); off_a = 0;
    chk("t7_park_pend", pend_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_sig", sig_a, 0);
    chk("t7_rst_busy", busy_a, 0);
    chk("t7_rst_pend", pend_a, 0);
    chk("t7_rst_edges", edges_a, 0);
    chk("t7_rst_err", err_a, 0);
    #2 rst = 1'b0;
    on_a = 1; tick(); on_a = 0;
    chk("t7_post_sig", sig_a, 1);
    chk("t7_post_edges", edges_a, 1);
    chk("t7_post_busy", busy_a, 1);
    chk("t7_post_pend", pend_a, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
